mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg : shared state encoding and default widths for the
//                        instruction/data memory port arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_port_arbiter_pkg;

  localparam int DEF_AW           = 32;
  localparam int DEF_DW           = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one memory port between instruction fetch and
//                    load/store, one outstanding transaction at a time.
// Optional macro ARB_STARVE_GUARD_EN: bounded data priority over fetch.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata
);

  arb_state_e r_state;
  arb_state_e w_state_next;
  logic       w_starve;
  logic       w_sel_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] r_starve_cnt;

  assign w_starve = (r_starve_cnt == CW'(STARVE_LIMIT));

  // Counts data grants that jumped over a pending fetch; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_starve_cnt <= '0;
    else if (!i_req || i_gnt)
      r_starve_cnt <= '0;
    else if (d_gnt && !w_starve)
      r_starve_cnt <= r_starve_cnt + 1'b1;
  end
`else
  assign w_starve = 1'b0;
`endif

  assign w_sel_d = d_req & ~(w_starve & i_req);

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    m_req        = 1'b0;
    m_we         = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;
    m_wstrb      = '0;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    i_rvalid     = 1'b0;
    d_rvalid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst) begin
          m_req = i_req | d_req;
          if (w_sel_d) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_wstrb = d_wstrb;
          end else if (i_req) begin
            m_addr = i_addr;
          end
          if (m_gnt) begin
            if (w_sel_d) begin
              d_gnt        = 1'b1;
              w_state_next = BUSY_D;
            end else if (i_req) begin
              i_gnt        = 1'b1;
              w_state_next = BUSY_I;
            end
          end
        end
      end
      BUSY_I: begin
        if (m_rvalid) begin
          i_rvalid     = 1'b1;
          w_state_next = IDLE;
        end
      end
      BUSY_D: begin
        if (m_rvalid) begin
          d_rvalid     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed bench with a transaction-level reference
//                       model compared against the arbiter every cycle.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW           = 32;
  localparam int DW           = 32;
  localparam int STARVE_LIMIT = 4;

  logic            clk;
  logic            rst;
  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic            i_gnt;
  logic            i_rvalid;
  logic [DW-1:0]   i_rdata;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wstrb;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            m_req;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_gnt;
  logic            m_rvalid;
  logic [DW-1:0]   m_rdata;

  int errors   = 0;
  int checks   = 0;
  bit model_on = 0;

  // Reference model: who owns the memory (0 none, 1 fetch, 2 data) and how
  // many data grants in a row have been taken while a fetch was waiting.
  int mdl_owner  = 0;
  int mdl_streak = 0;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mdl_data_wins();
`ifdef ARB_STARVE_GUARD_EN
    return d_req && !(i_req && mdl_streak >= STARVE_LIMIT);
`else
    return d_req;
`endif
  endfunction

  function automatic bit mdl_dg();
    return !rst && mdl_owner == 0 && m_gnt && mdl_data_wins();
  endfunction

  function automatic bit mdl_ig();
    return !rst && mdl_owner == 0 && m_gnt && i_req && !mdl_data_wins();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_owner  <= 0;
      mdl_streak <= 0;
    end else begin
      if (mdl_owner != 0) begin
        if (m_rvalid) mdl_owner <= 0;
      end else if (mdl_dg()) begin
        mdl_owner <= 2;
      end else if (mdl_ig()) begin
        mdl_owner <= 1;
      end
      if (!i_req || mdl_ig())
        mdl_streak <= 0;
      else if (mdl_dg() && mdl_streak < STARVE_LIMIT)
        mdl_streak <= mdl_streak + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      logic            e_req, e_we;
      logic [AW-1:0]   e_addr;
      logic [DW-1:0]   e_wdata;
      logic [DW/8-1:0] e_wstrb;
      bit              idle;
      idle    = !rst && mdl_owner == 0;
      e_req   = idle && (i_req || d_req);
      e_we    = 1'b0;
      e_addr  = '0;
      e_wdata = '0;
      e_wstrb = '0;
      if (idle && mdl_data_wins()) begin
        e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_wstrb = d_wstrb;
      end else if (idle && i_req) begin
        e_addr = i_addr;
      end
      chk("mdl_i_gnt", i_gnt, mdl_ig());
      chk("mdl_d_gnt", d_gnt, mdl_dg());
      chk("mdl_m_req", m_req, e_req);
      chk("mdl_i_rvalid", i_rvalid, !rst && mdl_owner == 1 && m_rvalid);
      chk("mdl_d_rvalid", d_rvalid, !rst && mdl_owner == 2 && m_rvalid);
      chk("mdl_i_rdata", i_rdata, m_rdata);
      chk("mdl_d_rdata", d_rdata, m_rdata);
      if (idle || rst) begin
        chk("mdl_m_we", m_we, e_we);
        chk("mdl_m_addr", m_addr, e_addr);
        chk("mdl_m_wdata", m_wdata, e_wdata);
        chk("mdl_m_wstrb", m_wstrb, e_wstrb);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int grants;
    logic [1:0] exp_kind;
    rst = 1'b1;
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_on = 1;

    // Reset state
    @(negedge clk);
    chk("reset_i_gnt", i_gnt, 1'b0);
    chk("reset_d_gnt", d_gnt, 1'b0);
    chk("reset_m_req", m_req, 1'b0);
    chk("reset_m_addr", m_addr, 32'h0);

    // Single fetch with one-cycle response
    cyc();
    i_req = 1; i_addr = 32'h0800_0000; m_gnt = 1;
    @(negedge clk);
    chk("fetch_i_gnt", i_gnt, 1'b1);
    chk("fetch_m_addr", m_addr, 32'h0800_0000);
    chk("fetch_m_we", m_we, 1'b0);
    cyc();
    i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("fetch_i_rvalid", i_rvalid, 1'b1);
    chk("fetch_i_rdata", i_rdata, 32'h0000_0013);
    chk("fetch_d_rvalid", d_rvalid, 1'b0);
    cyc();
    m_rvalid = 0;

    // Simultaneous requests: data store first, fetch two cycles later
    i_req = 1; i_addr = 32'h0800_0004;
    d_req = 1; d_we = 1; d_addr = 32'h2000_0000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    m_gnt = 1;
    @(negedge clk);
    chk("both_d_gnt", d_gnt, 1'b1);
    chk("both_i_gnt0", i_gnt, 1'b0);
    chk("both_m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("both_m_we", m_we, 1'b1);
    chk("both_m_wstrb", m_wstrb, 4'hF);
    cyc();
    d_req = 0; d_we = 0; m_rvalid = 1; m_rdata = 32'h0;
    @(negedge clk);
    chk("both_d_ack", d_rvalid, 1'b1);
    chk("both_resp_no_gnt", i_gnt, 1'b0);
    cyc();
    m_rvalid = 0;
    @(negedge clk);
    chk("both_i_gnt2", i_gnt, 1'b1);
    chk("both_i_addr", m_addr, 32'h0800_0004);
    cyc();
    i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("both_i_rvalid", i_rvalid, 1'b1);
    cyc();
    m_rvalid = 0;

    // Memory stalls for three cycles
    i_req = 1; i_addr = 32'h0800_0100; m_gnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_i_gnt", i_gnt, 1'b0);
      chk("stall_m_req", m_req, 1'b1);
      chk("stall_m_addr", m_addr, 32'h0800_0100);
      cyc();
    end
    m_gnt = 1;
    @(negedge clk);
    chk("stall_grant4", i_gnt, 1'b1);
    cyc();
    i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("stall_i_rvalid", i_rvalid, 1'b1);
    cyc();
    m_rvalid = 0;
    cyc();

    // Continuous contention; m_rvalid held high is ignored while idle
    i_req = 1; i_addr = 32'h0800_0200;
    d_req = 1; d_we = 0; d_addr = 32'h2000_0100;
    m_gnt = 1; m_rvalid = 1; m_rdata = 32'h5555_AAAA;
    grants = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (i_gnt || d_gnt) begin
`ifdef ARB_STARVE_GUARD_EN
        exp_kind = (grants % 5 == 4) ? 2'b10 : 2'b01;
`else
        exp_kind = 2'b01;
`endif
        chk("starve_seq", {i_gnt, d_gnt}, exp_kind);
        grants++;
      end
      cyc();
    end
    chk("starve_grant_count", grants, 10);
    i_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 0;
    cyc();

    // Reset while a load is in flight; its late response must be dropped
    d_req = 1; d_we = 0; d_addr = 32'h2000_0040; m_gnt = 1;
    @(negedge clk);
    chk("rst_d_gnt", d_gnt, 1'b1);
    cyc();
    d_req = 0; m_gnt = 0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_req", m_req, 1'b0);
    cyc();
    m_rvalid = 1; m_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("rst_late_d_rvalid", d_rvalid, 1'b0);
    chk("rst_late_i_rvalid", i_rvalid, 1'b0);
    cyc();
    m_rvalid = 0; i_req = 1; i_addr = 32'h0800_0300; m_gnt = 1;
    @(negedge clk);
    chk("rst_after_i_gnt", i_gnt, 1'b1);
    cyc();
    i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0000_0093;
    @(negedge clk);
    chk("rst_after_i_rvalid", i_rvalid, 1'b1);
    chk("rst_after_i_rdata", i_rdata, 32'h0000_0093);
    cyc();
    m_rvalid = 0;
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
